axis_frame_scheduler: RTL and testbench

//  Sequences whole video frames into the vga_controller AXI-Stream input (s_axis_*).

---
 rtl/axis_frame_scheduler.sv | 158 +++++++++++++++
 tb/tb_axis_frame_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_scheduler.sv
// AXI-Stream test-pattern source: emits whole RGB565 frames with tuser/tlast framing.
// Pattern selection and enable take effect only between frames.
module axis_frame_scheduler #(
   parameter int          H_ACTIVE   = 1024,
   parameter int          V_ACTIVE   = 768,
   parameter int          GAP_CYCLES = 16,
   parameter int          CHK_SH     = 5,
   parameter logic [15:0] SOLID_RGB  = 16'h001F
) (
   input  logic        axi_clk,
   input  logic        axi_rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [1:0]  active_pattern
);

   localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

   state_t           state, next_state;
   logic             start_frame;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [2:0]       bar_idx;
   logic [SUB_W-1:0] bar_sub;
   logic [GAP_W-1:0] gap_cnt;
   logic             hs, last_x, last_y, last_beat, gap_end;
   logic [15:0]      xe, ye, pix;
   logic             chk;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 16'hFFFF;
         3'd1:    bar_colour = 16'hFFE0;
         3'd2:    bar_colour = 16'h07FF;
         3'd3:    bar_colour = 16'h07E0;
         3'd4:    bar_colour = 16'hF81F;
         3'd5:    bar_colour = 16'hF800;
         3'd6:    bar_colour = 16'h001F;
         default: bar_colour = 16'h0000;
      endcase
   endfunction

   assign hs        = (state == STREAM) & m_axis_tready;
   assign last_x    = (x == X_W'(H_ACTIVE - 1));
   assign last_y    = (y == Y_W'(V_ACTIVE - 1));
   assign last_beat = hs & last_x & last_y;
   assign gap_end   = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

   always_ff @(posedge axi_clk) begin
      if (axi_rst) state <= IDLE;
      else         state <= next_state;
   end

   // Frame boundaries are the only points where enable/pattern_sel are honoured.
   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               start_frame = 1'b1;
               next_state  = STREAM;
            end
         end
         STREAM: begin
            if (last_beat) begin
               if (GAP_CYCLES != 0) next_state = GAP;
               else if (enable)     start_frame = 1'b1;
               else                 next_state = IDLE;
            end
         end
         GAP: begin
            if (gap_end) begin
               if (enable) begin
                  start_frame = 1'b1;
                  next_state  = STREAM;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Bar sub-counter tracks the position inside the current colour bar.
   always_ff @(posedge axi_clk) begin
      if (axi_rst || start_frame) begin
         x       <= '0;
         y       <= '0;
         bar_idx <= 3'd0;
         bar_sub <= '0;
      end else if (hs) begin
         if (last_x) begin
            x       <= '0;
            bar_idx <= 3'd0;
            bar_sub <= '0;
            y       <= last_y ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
            if (bar_sub == SUB_W'(BAR_W - 1)) begin
               bar_sub <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_sub <= bar_sub + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         gap_cnt        <= '0;
         frame_cnt      <= 16'd0;
         frame_done     <= 1'b0;
         active_pattern <= 2'd0;
      end else begin
         if (state == GAP) gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
         else              gap_cnt <= '0;
         if (last_beat)   frame_cnt <= frame_cnt + 16'd1;
         frame_done <= last_beat;
         if (start_frame) active_pattern <= pattern_sel;
      end
   end

   always_comb begin
      xe  = 16'(x);
      ye  = 16'(y);
      chk = (((xe >> CHK_SH) ^ (ye >> CHK_SH)) & 16'd1) != 16'd0;
      case (active_pattern)
         2'd0:    pix = bar_colour(bar_idx);
         2'd1:    pix = chk ? 16'hFFFF : 16'h0000;
         2'd2:    pix = {xe[4:0], ye[5:0], frame_cnt[4:0]};
         default: pix = SOLID_RGB;
      endcase
   end

   assign m_axis_tvalid = (state == STREAM);
   assign m_axis_tdata  = m_axis_tvalid ? pix : 16'h0000;
   assign m_axis_tuser  = m_axis_tvalid & (x == '0) & (y == '0);
   assign m_axis_tlast  = m_axis_tvalid & last_x;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Directed bench for axis_frame_scheduler on an 8x4 frame: one DUT with a 2-cycle gap,
// one with back-to-back frames.
module tb_axis_frame_scheduler;
   localparam int NB = 32;

   logic        clk = 1'b0;
   logic        rst, enable, tready;
   logic [1:0]  sel;
   logic [15:0] tdata, frame_cnt;
   logic        tuser, tlast, tvalid, frame_done, busy;
   logic [1:0]  act_pat;

   logic        g_rst, g_enable, g_tready;
   logic [1:0]  g_sel;
   logic [15:0] g_tdata, g_frame_cnt;
   logic        g_tuser, g_tlast, g_tvalid, g_frame_done, g_busy;
   logic [1:0]  g_act_pat;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axis_frame_scheduler #(.H_ACTIVE(8), .V_ACTIVE(4), .GAP_CYCLES(2), .CHK_SH(1),
                          .SOLID_RGB(16'h001F)) dut (
      .axi_clk(clk), .axi_rst(rst), .enable(enable), .pattern_sel(sel),
      .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .frame_done(frame_done),
      .busy(busy), .frame_cnt(frame_cnt), .active_pattern(act_pat));

   axis_frame_scheduler #(.H_ACTIVE(8), .V_ACTIVE(4), .GAP_CYCLES(0), .CHK_SH(1),
                          .SOLID_RGB(16'h001F)) dut_nogap (
      .axi_clk(clk), .axi_rst(g_rst), .enable(g_enable), .pattern_sel(g_sel),
      .m_axis_tdata(g_tdata), .m_axis_tuser(g_tuser), .m_axis_tlast(g_tlast),
      .m_axis_tvalid(g_tvalid), .m_axis_tready(g_tready), .frame_done(g_frame_done),
      .busy(g_busy), .frame_cnt(g_frame_cnt), .active_pattern(g_act_pat));

   typedef struct {
      int          beat;
      logic [15:0] data;
      logic        user;
      logic        last;
   } vec_t;

   vec_t        bars_tbl [NB];
   vec_t        chk_tbl  [4];
   logic [15:0] bar_colour [8];
   logic [15:0] cap_data [NB];
   logic        cap_user [NB];
   logic        cap_last [NB];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string nm, input logic a, input logic e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, a, e);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] a, input logic [15:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, a, e);
      end
   endtask

   // Capture 32 accepted beats; optionally act on the inputs once beat hook_beat is accepted.
   task automatic collect(input bit rnd, input int hook_beat, input int hook_kind, input string tag);
      int          n = 0;
      int          cyc = 0;
      bit          stalled = 1'b0;
      logic [15:0] pd = 16'h0000;
      logic        pu = 1'b0;
      logic        pl = 1'b0;
      while (n < NB && cyc < 1000) begin
         if (stalled) begin
            chk1({tag, " stall tvalid"}, tvalid, 1'b1);
            chk16({tag, " stall tdata"}, tdata, pd);
            chk1({tag, " stall tuser"}, tuser, pu);
            chk1({tag, " stall tlast"}, tlast, pl);
         end
         tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 1'b0;
         if (tvalid) begin
            if (tready) begin
               cap_data[n] = tdata;
               cap_user[n] = tuser;
               cap_last[n] = tlast;
               if (n == hook_beat) begin
                  if (hook_kind == 1) sel = 2'd1;
                  else if (hook_kind == 2) enable = 1'b0;
               end
               n++;
            end else begin
               stalled = 1'b1;
               pd = tdata;
               pu = tuser;
               pl = tlast;
            end
         end
         step();
         cyc++;
      end
      n_checks++;
      if (n != NB) begin
         n_fail++;
         $display("FAIL %s handshakes: got %0d, expected %0d", tag, n, NB);
      end
   endtask

   task automatic cmp_bars(input string tag);
      for (int i = 0; i < NB; i++) begin
         chk16($sformatf("%s beat%0d tdata", tag, bars_tbl[i].beat), cap_data[bars_tbl[i].beat], bars_tbl[i].data);
         chk1($sformatf("%s beat%0d tuser", tag, bars_tbl[i].beat), cap_user[bars_tbl[i].beat], bars_tbl[i].user);
         chk1($sformatf("%s beat%0d tlast", tag, bars_tbl[i].beat), cap_last[bars_tbl[i].beat], bars_tbl[i].last);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int hs;
      int cyc;
      bar_colour = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      for (int i = 0; i < NB; i++)
         bars_tbl[i] = '{beat: i, data: bar_colour[i % 8], user: (i == 0), last: ((i % 8) == 7)};
      chk_tbl[0] = '{beat: 0,  data: 16'h0000, user: 1'b1, last: 1'b0};
      chk_tbl[1] = '{beat: 2,  data: 16'hFFFF, user: 1'b0, last: 1'b0};
      chk_tbl[2] = '{beat: 16, data: 16'hFFFF, user: 1'b0, last: 1'b0};
      chk_tbl[3] = '{beat: 18, data: 16'h0000, user: 1'b0, last: 1'b0};

      rst = 1'b1; enable = 1'b0; sel = 2'd0; tready = 1'b0;
      g_rst = 1'b1; g_enable = 1'b0; g_sel = 2'd0; g_tready = 1'b0;
      step();
      step();
      chk1("rst tvalid", tvalid, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chk1("rst frame_done", frame_done, 1'b0);
      chk1("rst tuser", tuser, 1'b0);
      chk1("rst tlast", tlast, 1'b0);
      chk16("rst tdata", tdata, 16'h0000);
      chk16("rst frame_cnt", frame_cnt, 16'd0);
      chk16("rst active_pattern", 16'(act_pat), 16'd0);
      chk1("rst nogap tvalid", g_tvalid, 1'b0);
      chk16("rst nogap frame_cnt", g_frame_cnt, 16'd0);
      rst = 1'b0; g_rst = 1'b0;
      step();
      chk1("idle tvalid", tvalid, 1'b0);
      chk1("idle busy", busy, 1'b0);

      // Test 1: colour bars, always ready
      enable = 1'b1; sel = 2'd0; tready = 1'b1;
      step();
      chk1("t1 first tvalid", tvalid, 1'b1);
      chk1("t1 first tuser", tuser, 1'b1);
      chk1("t1 busy", busy, 1'b1);
      collect(1'b0, -1, 0, "t1");
      cmp_bars("t1");
      chk1("t1 frame_done", frame_done, 1'b1);
      chk16("t1 frame_cnt", frame_cnt, 16'd1);
      chk1("t1 gap0 tvalid", tvalid, 1'b0);
      chk1("t1 gap0 busy", busy, 1'b1);
      step();
      chk1("t1 gap1 tvalid", tvalid, 1'b0);
      chk1("t1 frame_done width", frame_done, 1'b0);
      step();
      chk1("t1 restart tvalid", tvalid, 1'b1);
      chk1("t1 restart tuser", tuser, 1'b1);
      chk16("t1 restart tdata", tdata, 16'hFFFF);

      // Test 2: random back-pressure
      collect(1'b1, -1, 0, "t2");
      cmp_bars("t2");
      chk1("t2 frame_done", frame_done, 1'b1);
      chk16("t2 frame_cnt", frame_cnt, 16'd2);
      chk1("t2 no extra beat", tvalid, 1'b0);

      // Test 3: pattern change mid-frame applies to the next frame
      collect(1'b0, 10, 1, "t3");
      cmp_bars("t3");
      chk16("t3 active_pattern", 16'(act_pat), 16'd0);
      chk16("t3 frame_cnt", frame_cnt, 16'd3);
      collect(1'b0, -1, 0, "t3b");
      for (int i = 0; i < 4; i++) begin
         chk16($sformatf("t3b beat%0d tdata", chk_tbl[i].beat), cap_data[chk_tbl[i].beat], chk_tbl[i].data);
         chk1($sformatf("t3b beat%0d tuser", chk_tbl[i].beat), cap_user[chk_tbl[i].beat], chk_tbl[i].user);
      end
      chk16("t3b active_pattern", 16'(act_pat), 16'd1);
      chk16("t3b frame_cnt", frame_cnt, 16'd4);
      sel = 2'd0;

      // Test 4: enable dropped mid-frame
      collect(1'b0, 10, 2, "t4");
      cmp_bars("t4");
      chk1("t4 frame_done", frame_done, 1'b1);
      chk16("t4 frame_cnt", frame_cnt, 16'd5);
      chk1("t4 gap busy", busy, 1'b1);
      step();
      step();
      chk1("t4 idle busy", busy, 1'b0);
      chk1("t4 idle tvalid", tvalid, 1'b0);
      chk16("t4 idle frame_cnt", frame_cnt, 16'd5);
      step();
      chk1("t4 idle hold tvalid", tvalid, 1'b0);

      // Test 5: reset during a stalled beat
      enable = 1'b1; tready = 1'b1;
      step();
      hs = 0;
      cyc = 0;
      while (hs < 12 && cyc < 200) begin
         if (tvalid) hs++;
         step();
         cyc++;
      end
      n_checks++;
      if (hs != 12) begin
         n_fail++;
         $display("FAIL t5 handshakes: got %0d, expected 12", hs);
      end
      chk16("t5 beat12 tdata", tdata, 16'hF81F);
      tready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk1("t5 rst tvalid", tvalid, 1'b0);
      chk16("t5 rst frame_cnt", frame_cnt, 16'd0);
      chk1("t5 rst busy", busy, 1'b0);
      chk1("t5 rst frame_done", frame_done, 1'b0);
      step();
      chk1("t5 restart tvalid", tvalid, 1'b1);
      chk1("t5 restart tuser", tuser, 1'b1);
      chk16("t5 restart tdata", tdata, 16'hFFFF);
      enable = 1'b0;

      // Test 6: back-to-back frames, ramp pattern
      g_enable = 1'b1; g_sel = 2'd2; g_tready = 1'b1;
      step();
      for (int b = 0; b < NB; b++) begin
         chk1($sformatf("t6 beat%0d tvalid", b), g_tvalid, 1'b1);
         if (b == 0) begin
            chk1("t6 beat0 tuser", g_tuser, 1'b1);
            chk16("t6 beat0 tdata", g_tdata, 16'h0000);
         end
         if (b == 9) chk16("t6 beat9 tdata", g_tdata, 16'h0820);
         if (b == 31) begin
            chk1("t6 beat31 tlast", g_tlast, 1'b1);
            chk16("t6 beat31 tdata", g_tdata, 16'h3860);
         end
         step();
      end
      chk1("t6 next tvalid", g_tvalid, 1'b1);
      chk1("t6 next tuser", g_tuser, 1'b1);
      chk16("t6 next tdata", g_tdata, 16'h0001);
      chk1("t6 frame_done", g_frame_done, 1'b1);
      chk16("t6 frame_cnt", g_frame_cnt, 16'd1);
      chk16("t6 active_pattern", 16'(g_act_pat), 16'd2);
      g_enable = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
